pll_freq_checker: RTL and testbench

- Parametrised multi-channel successor to the PLL tester's per-output counter LEDs.
- Takes N_CH slow toggling signals and the PLL LOCKED flag. Typical toggling sources are divided-clock MSBs from the PLL/MMCM tester.
- Counts rising edges of each channel over a fixed gate window of CLK cycles. Checks each count against per-channel min/max bounds and reports pass/fail, lock loss and lock timeout.
- Sits between the PLL tester and board LEDs/UART. Single CLK domain; toggle inputs are treated as asynchronous data.

---
 rtl/pll_freq_checker.sv | 201 ++++++++++++++++++++
 tb/tb_pll_freq_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_freq_checker.sv
// pll_freq_checker
//   Counts rising edges on N_CH slow toggling inputs over a fixed gate
//   window once the PLL reports lock, then checks every count against
//   per-channel inclusive [min, max] bounds.
//
// Ports
//   CLK          system clock
//   RST          asynchronous active-low reset
//   I_START      start / re-arm request, honoured only in IDLE or DONE
//   I_LOCKED     PLL lock flag (asynchronous, synchronised here)
//   I_TOG        toggling channel inputs (asynchronous, synchronised here)
//   I_EXP_MIN    per-channel lower bounds, channel k at [k*CNT_W +: CNT_W]
//   I_EXP_MAX    per-channel upper bounds, same packing
//   O_BUSY       run in progress (WAIT_LOCK / SETTLE / MEASURE / CHECK)
//   O_DONE       results valid
//   O_PASS       per-channel in-range result
//   O_LOCK_LOST  lock dropped while settling or measuring
//   O_TIMEOUT    lock never seen within LOCK_TIMEOUT cycles
//   O_COUNT      captured edge counts, same packing as the bounds
module pll_freq_checker #(
  parameter int N_CH          = 6,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 4000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   I_START,
  input  logic                   I_LOCKED,
  input  logic [N_CH-1:0]        I_TOG,
  input  logic [N_CH*CNT_W-1:0]  I_EXP_MIN,
  input  logic [N_CH*CNT_W-1:0]  I_EXP_MAX,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic [N_CH-1:0]        O_PASS,
  output logic                   O_LOCK_LOST,
  output logic                   O_TIMEOUT,
  output logic [N_CH*CNT_W-1:0]  O_COUNT
);

  localparam int T_MAX1 = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int T_MAX  = (T_MAX1 > LOCK_TIMEOUT) ? T_MAX1 : LOCK_TIMEOUT;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOCK, SETTLE, MEASURE, CHECK, DONE
  } state_t;

  typedef logic [N_CH-1:0][CNT_W-1:0] cnt_vec_t;

  state_t                           state, state_nxt;
  logic [TMR_W-1:0]                 timer;
  logic [SYNC_STAGES-1:0][N_CH-1:0] tog_sync;
  logic [SYNC_STAGES-1:0]           lock_sync;
  logic [N_CH-1:0]                  tog_prev;
  logic [N_CH-1:0]                  tog_s;
  logic [N_CH-1:0]                  tog_rise;
  logic                             lock_s;
  logic                             arm;
  cnt_vec_t                         cnt;
  cnt_vec_t                         count_q;
  cnt_vec_t                         exp_min;
  cnt_vec_t                         exp_max;
  logic [N_CH-1:0]                  pass_q;
  logic                             lock_lost_q;
  logic                             timeout_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  assign exp_min  = I_EXP_MIN;
  assign exp_max  = I_EXP_MAX;
  assign tog_s    = tog_sync[SYNC_STAGES-1];
  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign tog_rise = tog_s & ~tog_prev;

  // Synchronisers and edge history run in every state, so the history is
  // already current when MEASURE begins and no spurious edge is counted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tog_sync  <= '0;
      lock_sync <= '0;
      tog_prev  <= '0;
    end else begin
      tog_sync  <= {tog_sync[SYNC_STAGES-2:0], I_TOG};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], I_LOCKED};
      tog_prev  <= tog_s;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (I_START) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                  state_nxt = SETTLE;
        else if (timer == LOCK_LAST) state_nxt = DONE;
      end
      SETTLE: begin
        if (!lock_s)                   state_nxt = DONE;
        else if (timer == SETTLE_LAST) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!lock_s)                 state_nxt = DONE;
        else if (timer == GATE_LAST) state_nxt = CHECK;
      end
      CHECK:     state_nxt = DONE;
      DONE:      if (I_START) state_nxt = WAIT_LOCK;
      default:   state_nxt = IDLE;
    endcase
  end

  // Entering WAIT_LOCK from IDLE or DONE starts a fresh run.
  assign arm = (state_nxt == WAIT_LOCK) && (state != WAIT_LOCK);

  // One shared timer; it restarts at zero on every state change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer <= '0;
    end else if ((state_nxt != state) ||
                 !(state inside {WAIT_LOCK, SETTLE, MEASURE})) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt         <= '0;
      count_q     <= '0;
      pass_q      <= '0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (arm) begin
      cnt         <= '0;
      count_q     <= '0;
      pass_q      <= '0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (state_nxt == DONE) begin
            timeout_q <= 1'b1;
            pass_q    <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            lock_lost_q <= 1'b1;
            pass_q      <= '0;
            count_q     <= cnt;
          end else if (state_nxt == MEASURE) begin
            cnt <= '0;
          end
        end
        MEASURE: begin
          if (!lock_s) begin
            lock_lost_q <= 1'b1;
            pass_q      <= '0;
            count_q     <= cnt;
          end else begin
            for (int k = 0; k < N_CH; k++) cnt[k] <= sat_inc(cnt[k], tog_rise[k]);
          end
        end
        CHECK: begin
          count_q <= cnt;
          for (int k = 0; k < N_CH; k++) pass_q[k] <= in_range(cnt[k], exp_min[k], exp_max[k]);
        end
        default: ;
      endcase
    end
  end

  assign O_BUSY      = state inside {WAIT_LOCK, SETTLE, MEASURE, CHECK};
  assign O_DONE      = (state == DONE);
  assign O_PASS      = pass_q;
  assign O_LOCK_LOST = lock_lost_q;
  assign O_TIMEOUT   = timeout_q;
  assign O_COUNT     = count_q;

endmodule

// File: tb/tb_pll_freq_checker.sv
// Testbench for pll_freq_checker: two instances sharing clock and reset,
// one with 8-bit counters for the functional vectors and one with 4-bit
// counters for counter saturation.
module tb_pll_freq_checker;

  logic        clk;
  logic        rst_n;

  logic        start_a, lock_a;
  logic [1:0]  tog_a;
  logic [15:0] min_a, max_a;
  logic        busy_a, done_a, lost_a, to_a;
  logic [1:0]  pass_a;
  logic [15:0] cnt_a;

  logic        start_b, lock_b;
  logic [1:0]  tog_b;
  logic [7:0]  min_b, max_b;
  logic        busy_b, done_b, lost_b, to_b;
  logic [1:0]  pass_b;
  logic [7:0]  cnt_b;

  int p0_a, p1_a, p0_b;
  int n_chk, n_fail;

  pll_freq_checker #(
    .N_CH(2), .CNT_W(8), .GATE_CYCLES(100), .SETTLE_CYCLES(8),
    .LOCK_TIMEOUT(50), .SYNC_STAGES(2)
  ) dut_a (
    .CLK(clk), .RST(rst_n), .I_START(start_a), .I_LOCKED(lock_a),
    .I_TOG(tog_a), .I_EXP_MIN(min_a), .I_EXP_MAX(max_a),
    .O_BUSY(busy_a), .O_DONE(done_a), .O_PASS(pass_a),
    .O_LOCK_LOST(lost_a), .O_TIMEOUT(to_a), .O_COUNT(cnt_a)
  );

  pll_freq_checker #(
    .N_CH(2), .CNT_W(4), .GATE_CYCLES(100), .SETTLE_CYCLES(8),
    .LOCK_TIMEOUT(50), .SYNC_STAGES(2)
  ) dut_b (
    .CLK(clk), .RST(rst_n), .I_START(start_b), .I_LOCKED(lock_b),
    .I_TOG(tog_b), .I_EXP_MIN(min_b), .I_EXP_MAX(max_b),
    .O_BUSY(busy_b), .O_DONE(done_b), .O_PASS(pass_b),
    .O_LOCK_LOST(lost_b), .O_TIMEOUT(to_b), .O_COUNT(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic sq(input int ph, input int p);
    return (p > 0) && ((ph % p) < (p / 2));
  endfunction

  // Square-wave sources with the requested periods (0 = held low).
  initial begin
    int ph;
    ph = 0;
    tog_a = 2'b00;
    tog_b = 2'b00;
    forever begin
      @(negedge clk);
      ph++;
      tog_a = {sq(ph, p1_a), sq(ph, p0_a)};
      tog_b = {1'b0, sq(ph, p0_b)};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Pulses START on instance A and returns the number of clock edges from
  // the edge that sampled START to the first edge showing O_DONE.
  task automatic run_a(input bit noisy, output int lat);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 0;
    chk("busy_after_start", int'(busy_a), 1);
    while (!done_a && lat < 300) begin
      @(negedge clk);
      lat++;
      start_a = noisy && !done_a && (lat % 20 == 10);
    end
    start_a = 1'b0;
    chk("done_reached", int'(done_a), 1);
  endtask

  typedef struct {
    string name;
    int p0, p1, lock;
    int mn0, mx0, mn1, mx1;
    int pass, c0, c1, to;
    int lat_lo, lat_hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, n;
    n_chk = 0;
    n_fail = 0;

    vecs[0] = '{"nominal",   10, 20, 1,  9, 11, 4, 6, 3, 10, 5, 0, 109, 113};
    vecs[1] = '{"ch1_static",10,  0, 1,  9, 11, 4, 6, 1, 10, 0, 0, 109, 113};
    vecs[2] = '{"min_gt_max",10, 20, 1, 10, 10, 6, 4, 1, 10, 5, 0, 109, 113};
    vecs[3] = '{"inclusive", 10, 20, 1, 11, 20, 0, 5, 2, 10, 5, 0, 109, 113};
    vecs[4] = '{"timeout",   10, 20, 0,  9, 11, 4, 6, 0,  0, 0, 1,  49,  53};

    rst_n = 1'b0;
    start_a = 1'b0; lock_a = 1'b1; min_a = '0; max_a = '0;
    start_b = 1'b0; lock_b = 1'b1; min_b = '0; max_b = '0;
    p0_a = 10; p1_a = 20; p0_b = 4;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_flags", int'({lost_a, to_a}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(busy_a), 0);

    foreach (vecs[i]) begin
      p0_a   = vecs[i].p0;
      p1_a   = vecs[i].p1;
      lock_a = logic'(vecs[i].lock);
      min_a  = {8'(vecs[i].mn1), 8'(vecs[i].mn0)};
      max_a  = {8'(vecs[i].mx1), 8'(vecs[i].mx0)};
      repeat (6) @(negedge clk);
      run_a(1'b0, lat);
      chk_rng({vecs[i].name, "_latency"}, lat, vecs[i].lat_lo, vecs[i].lat_hi);
      chk({vecs[i].name, "_pass"}, int'(pass_a), vecs[i].pass);
      chk({vecs[i].name, "_cnt0"}, int'(cnt_a[7:0]), vecs[i].c0);
      chk({vecs[i].name, "_cnt1"}, int'(cnt_a[15:8]), vecs[i].c1);
      chk({vecs[i].name, "_timeout"}, int'(to_a), vecs[i].to);
      chk({vecs[i].name, "_lost"}, int'(lost_a), 0);
      chk({vecs[i].name, "_busy"}, int'(busy_a), 0);
    end

    // Lock loss at MEASURE cycle 40 (MEASURE starts 9 edges after START).
    lock_a = 1'b1; p0_a = 10; p1_a = 20;
    min_a = {8'd4, 8'd9}; max_a = {8'd6, 8'd11};
    repeat (6) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (49) @(negedge clk);
    chk("ll_busy_before", int'(busy_a), 1);
    lock_a = 1'b0;
    n = 0;
    while (!done_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_rng("ll_latency", n, 1, 3);
    chk("ll_lost", int'(lost_a), 1);
    chk("ll_pass", int'(pass_a), 0);
    chk("ll_timeout", int'(to_a), 0);
    chk_rng("ll_cnt0", int'(cnt_a[7:0]), 3, 5);
    lock_a = 1'b1;

    // Saturation on the 4-bit instance: 25 edges clamp at 15.
    min_b = {4'd0, 4'd0, 4'd0, 4'd15};
    max_b = {4'd0, 4'd0, 4'd0, 4'd15};
    repeat (6) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done", int'(done_b), 1);
    chk("sat_cnt0", int'(cnt_b[3:0]), 15);
    chk("sat_cnt1", int'(cnt_b[7:4]), 0);
    chk("sat_pass", int'(pass_b), 3);

    // Asynchronous reset mid-MEASURE on A while B holds results in DONE.
    repeat (6) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("ar_busy_before", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy_a), 0);
    chk("ar_done", int'(done_a), 0);
    chk("ar_b_done", int'(done_b), 0);
    chk("ar_b_count", int'(cnt_b), 0);
    chk("ar_b_pass", int'(pass_b), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle", int'({busy_a, done_a}), 0);

    // Re-arm with START pulses sprinkled through the busy period.
    repeat (6) @(negedge clk);
    run_a(1'b1, lat);
    chk_rng("rearm_latency", lat, 109, 113);
    chk("rearm_pass", int'(pass_a), 3);
    chk("rearm_cnt0", int'(cnt_a[7:0]), 10);
    chk("rearm_cnt1", int'(cnt_a[15:8]), 5);
    chk("rearm_flags", int'({lost_a, to_a}), 0);
    repeat (5) @(negedge clk);
    chk("done_held", int'(done_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
